// File: rtl/debug_host_initiator.sv
// Host-side initiator for the UART debug link: sends opcode + payload bytes to a
// uart_transmitter, then gathers a little-endian response from a uart_receiver.
module debug_host_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TIMEOUT_WIDTH  = 32
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Cmd_Valid,
  output logic        o_Cmd_Ready,
  input  logic [7:0]  i_Cmd_Op,
  input  logic [39:0] i_Cmd_Payload,
  input  logic [2:0]  i_Cmd_Tx_Len,
  input  logic [2:0]  i_Cmd_Rx_Len,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Done,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Rsp_Valid,
  output logic [31:0] o_Rsp_Data,
  output logic [2:0]  o_Rsp_Count,
  output logic        o_Rsp_Timeout,
  output logic        o_Stray_Rx
);

  typedef enum logic [2:0] {IDLE, SEND, GAP, RECV, DONE} state_t;

  state_t                   state, state_next;
  logic [39:0]              payload;
  logic [2:0]               tx_len, rx_len, idx;
  logic [TIMEOUT_WIDTH-1:0] tmo;
  logic                     accept, tx_more, rx_last, expire;

  assign o_Cmd_Ready = (state == IDLE);
  assign o_Rsp_Valid = (state == DONE);
  assign accept      = o_Cmd_Ready && i_Cmd_Valid;
  assign tx_more     = idx < tx_len;
  assign rx_last     = (o_Rsp_Count + 3'd1) == rx_len;
  assign expire      = tmo == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SEND;
      SEND: if (i_Tx_Done) state_next = GAP;
      GAP: begin
        if (tx_more)               state_next = SEND;
        else if (rx_len == 3'd0)   state_next = DONE;
        else                       state_next = RECV;
      end
      RECV: begin
        // an arriving byte takes precedence over a coincident timeout
        if (i_Rx_DV) begin
          if (rx_last) state_next = DONE;
        end else if (expire) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      payload       <= '0;
      tx_len        <= '0;
      rx_len        <= '0;
      idx           <= '0;
      tmo           <= '0;
      o_Tx_DV       <= 1'b0;
      o_Tx_Byte     <= '0;
      o_Rsp_Data    <= '0;
      o_Rsp_Count   <= '0;
      o_Rsp_Timeout <= 1'b0;
      o_Stray_Rx    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            payload       <= i_Cmd_Payload;
            tx_len        <= (i_Cmd_Tx_Len > 3'd5) ? 3'd5 : i_Cmd_Tx_Len;
            rx_len        <= (i_Cmd_Rx_Len > 3'd4) ? 3'd4 : i_Cmd_Rx_Len;
            idx           <= '0;
            o_Tx_DV       <= 1'b1;
            o_Tx_Byte     <= i_Cmd_Op;
            o_Rsp_Data    <= '0;
            o_Rsp_Count   <= '0;
            o_Rsp_Timeout <= 1'b0;
            o_Stray_Rx    <= 1'b0;
          end
        end
        SEND: if (i_Tx_Done) o_Tx_DV <= 1'b0;
        GAP: begin
          if (tx_more) begin
            // byte idx+1 on the wire is payload byte idx (opcode occupies slot 0)
            idx       <= idx + 3'd1;
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= payload[{idx, 3'b000} +: 8];
          end else begin
            tmo <= '0;
          end
        end
        RECV: begin
          if (i_Rx_DV) begin
            o_Rsp_Data[{o_Rsp_Count[1:0], 3'b000} +: 8] <= i_Rx_Byte;
            o_Rsp_Count <= o_Rsp_Count + 3'd1;
            tmo         <= '0;
          end else if (expire) begin
            o_Rsp_Timeout <= 1'b1;
          end else begin
            tmo <= tmo + TIMEOUT_WIDTH'(1);
          end
        end
        default: ;
      endcase
      if (i_Rx_DV && state != RECV) o_Stray_Rx <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_host_initiator.sv
// Randomised self-checking bench for debug_host_initiator with a transaction-level model.
`timescale 1ns/1ps
module tb_debug_host_initiator;
  localparam int unsigned TMO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_Cmd_Valid;
  logic        o_Cmd_Ready;
  logic [7:0]  i_Cmd_Op;
  logic [39:0] i_Cmd_Payload;
  logic [2:0]  i_Cmd_Tx_Len, i_Cmd_Rx_Len;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic        i_Tx_Done;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_Rsp_Valid;
  logic [31:0] o_Rsp_Data;
  logic [2:0]  o_Rsp_Count;
  logic        o_Rsp_Timeout;
  logic        o_Stray_Rx;

  always #5 clk = ~clk;

  debug_host_initiator #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(32)) dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_Cmd_Valid(i_Cmd_Valid), .o_Cmd_Ready(o_Cmd_Ready),
    .i_Cmd_Op(i_Cmd_Op), .i_Cmd_Payload(i_Cmd_Payload),
    .i_Cmd_Tx_Len(i_Cmd_Tx_Len), .i_Cmd_Rx_Len(i_Cmd_Rx_Len),
    .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Done(i_Tx_Done),
    .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Rsp_Valid(o_Rsp_Valid), .o_Rsp_Data(o_Rsp_Data), .o_Rsp_Count(o_Rsp_Count),
    .o_Rsp_Timeout(o_Rsp_Timeout), .o_Stray_Rx(o_Stray_Rx)
  );

  int unsigned errors = 0, checks = 0;
  int unsigned done_count = 0, valid_count = 0;
  logic [7:0]  tx_q[$];
  int unsigned gap_q[$];
  logic        prev_dv = 1'b0;
  logic [7:0]  hold_byte = '0;
  int unsigned wait_n = 0, idle_n = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},   o_Cmd_Ready,   1);
    check_eq({tag, "_txdv"},    o_Tx_DV,       0);
    check_eq({tag, "_txbyte"},  o_Tx_Byte,     0);
    check_eq({tag, "_valid"},   o_Rsp_Valid,   0);
    check_eq({tag, "_data"},    o_Rsp_Data,    0);
    check_eq({tag, "_count"},   o_Rsp_Count,   0);
    check_eq({tag, "_timeout"}, o_Rsp_Timeout, 0);
    check_eq({tag, "_stray"},   o_Stray_Rx,    0);
  endtask

  // Transmitter stand-in: records each byte, takes a random time, pulses done.
  initial begin
    i_Tx_Done = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_Tx_Done = 1'b0;
      if (o_Rsp_Valid === 1'b1) valid_count++;
      if (o_Tx_DV === 1'b1) begin
        if (!prev_dv) begin
          tx_q.push_back(o_Tx_Byte);
          gap_q.push_back(idle_n);
          hold_byte = o_Tx_Byte;
          wait_n = $urandom_range(0, 4);
        end else begin
          check_eq("tx_hold", o_Tx_Byte, hold_byte);
        end
        if (wait_n == 0) begin
          i_Tx_Done = 1'b1;
          done_count++;
        end else begin
          wait_n--;
        end
        idle_n = 0;
      end else begin
        idle_n++;
      end
      prev_dv = (o_Tx_DV === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=expired expected=finish");
    $fatal(1, "watchdog");
  end

  // Called just after a negedge; returns one negedge after the response pulse.
  task automatic run_cmd(input logic [7:0] op, input logic [39:0] pl, input logic [2:0] txl,
                         input logic [2:0] rxl, input int unsigned ndel, input logic [31:0] rbytes,
                         input bit stray_in, input bit hold);
    int unsigned txc, rxc, nstore, target, guard, k, exp_lat, vbase;
    logic [63:0] exp_data;
    logic [39:0] sh;
    txc = (txl > 5) ? 5 : int'(txl);
    rxc = (rxl > 4) ? 4 : int'(rxl);
    nstore = (ndel < rxc) ? ndel : rxc;
    exp_data = 64'(rbytes) & ((64'd1 << (8 * nstore)) - 64'd1);

    check_eq("ready_idle", o_Cmd_Ready, 1);
    i_Cmd_Valid = 1'b1; i_Cmd_Op = op; i_Cmd_Payload = pl;
    i_Cmd_Tx_Len = txl; i_Cmd_Rx_Len = rxl;
    tx_q.delete(); gap_q.delete();
    target = done_count + 1 + txc;
    vbase = valid_count;
    @(negedge clk);
    if (!hold) i_Cmd_Valid = 1'b0;
    check_eq("ready_busy", o_Cmd_Ready, 0);
    check_eq("clr_data", o_Rsp_Data, 0);
    check_eq("clr_count", o_Rsp_Count, 0);
    check_eq("clr_timeout", o_Rsp_Timeout, 0);
    check_eq("clr_stray", o_Stray_Rx, 0);
    if (stray_in) begin
      i_Rx_DV = 1'b1; i_Rx_Byte = 8'hEE;
      @(negedge clk);
      i_Rx_DV = 1'b0;
    end
    guard = 0;
    while (done_count < target && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_eq("tx_all_done", done_count >= target, 1);

    if (rxc == 0)       exp_lat = 2;
    else if (ndel == 0) exp_lat = TMO + 2;
    else begin
      for (int j = 0; j < int'(ndel); j++) begin
        if (j > 0) begin
          @(negedge clk);
          i_Rx_DV = 1'b0;
          repeat ($urandom_range(1, 5)) @(negedge clk);
        end else begin
          repeat ($urandom_range(2, 6)) @(negedge clk);
        end
        check_eq("no_early_rsp", valid_count, vbase);
        i_Rx_DV = 1'b1;
        i_Rx_Byte = rbytes[8*j +: 8];
      end
      exp_lat = (ndel >= rxc) ? 1 : TMO + 1;
    end

    k = 0;
    do begin
      @(negedge clk);
      i_Rx_DV = 1'b0;
      k++;
    end while (o_Rsp_Valid !== 1'b1 && k < TMO + 20);
    check_eq("rsp_latency", k, exp_lat);
    check_eq("rsp_data", o_Rsp_Data, exp_data);
    check_eq("rsp_count", o_Rsp_Count, nstore);
    check_eq("rsp_timeout", o_Rsp_Timeout, ndel < rxc);
    check_eq("rsp_stray", o_Stray_Rx, stray_in);
    check_eq("tx_nbytes", tx_q.size(), 1 + txc);
    for (int i = 0; i < tx_q.size() && i <= int'(txc); i++) begin
      sh = pl >> (8 * (i - 1));
      check_eq("tx_byte", tx_q[i], (i == 0) ? op : sh[7:0]);
      if (i > 0) check_eq("tx_gap", gap_q[i], 1);
    end
    @(negedge clk);
    check_eq("rsp_pulse", o_Rsp_Valid, 0);
    check_eq("rsp_once", valid_count, vbase + 1);
    check_eq("ready_after", o_Cmd_Ready, 1);
    check_eq("data_hold", o_Rsp_Data, exp_data);
  endtask

  initial begin
    int unsigned rxc, ndel, vb, txr, rxr;
    logic [39:0] pl;
    rst = 1'b1; i_Cmd_Valid = 0; i_Cmd_Op = 0; i_Cmd_Payload = 0;
    i_Cmd_Tx_Len = 0; i_Cmd_Rx_Len = 0; i_Rx_DV = 0; i_Rx_Byte = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    run_cmd(8'h05, 40'h0, 3'd0, 3'd1, 1, 32'h000000A5, 0, 0);
    run_cmd(8'h09, 40'h00_DEADBEEF_03, 3'd5, 3'd0, 0, 32'h0, 0, 0);
    run_cmd(8'h07, 40'h0, 3'd0, 3'd4, 4, 32'h12345678, 0, 0);
    run_cmd(8'h07, 40'h0, 3'd0, 3'd4, 2, 32'h00002211, 0, 0);
    run_cmd(8'h07, 40'h0, 3'd0, 3'd2, 0, 32'h0, 0, 0);

    // stray during SEND, then a byte beyond the response in IDLE
    run_cmd(8'h0B, 40'h00_0000_C0FFEE, 3'd3, 3'd2, 2, 32'h0000BEEF, 1, 0);
    run_cmd(8'h0C, 40'h0, 3'd0, 3'd1, 1, 32'h00000042, 0, 0);
    i_Rx_DV = 1'b1; i_Rx_Byte = 8'h99;
    @(negedge clk);
    i_Rx_DV = 1'b0;
    check_eq("extra_stray", o_Stray_Rx, 1);
    check_eq("extra_nostore", o_Rsp_Data, 32'h42);
    check_eq("extra_count", o_Rsp_Count, 1);

    // valid held across a busy command: second command only after the response
    run_cmd(8'h05, 40'h0, 3'd1, 3'd1, 1, 32'h0000005A, 0, 1);
    run_cmd(8'h06, 40'h0123456789, 3'd2, 3'd3, 3, 32'h00332211, 0, 0);

    // oversize lengths clamp to 5 / 4
    run_cmd(8'h0D, 40'hA1_B2C3D4E5, 3'd7, 3'd7, 4, 32'hCAFEF00D, 0, 0);

    // reset mid-RECV after one byte
    i_Cmd_Valid = 1'b1; i_Cmd_Op = 8'h07; i_Cmd_Payload = 0;
    i_Cmd_Tx_Len = 0; i_Cmd_Rx_Len = 3'd4;
    vb = valid_count + 1 - 1;
    vb = done_count + 1;
    @(negedge clk);
    i_Cmd_Valid = 1'b0;
    for (int g = 0; g < 100 && done_count < vb; g++) @(negedge clk);
    repeat (3) @(negedge clk);
    i_Rx_DV = 1'b1; i_Rx_Byte = 8'h5A;
    @(negedge clk);
    i_Rx_DV = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_reset_count", o_Rsp_Count, 1);
    vb = valid_count;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (TMO + 10) @(negedge clk);
    check_eq("midrst_novalid", valid_count, vb);
    check_reset_outputs("midrst_idle");
    run_cmd(8'h05, 40'h0, 3'd0, 3'd1, 1, 32'h000000C3, 0, 0);

    for (int n = 0; n < 12; n++) begin
      txr = $urandom_range(0, 7);
      rxr = $urandom_range(0, 7);
      rxc = (rxr > 4) ? 4 : rxr;
      ndel = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rxc) : rxc;
      pl = {8'($urandom), 32'($urandom)};
      run_cmd(8'($urandom), pl, 3'(txr), 3'(rxr), ndel, 32'($urandom),
              (txr >= 1) && ($urandom_range(0, 1) == 1), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
